// File: rtl/leaf_gpu_ingress_queue.sv
// rtl/leaf_gpu_ingress_queue.sv - show-ahead GPU injection queue in front of the leaf router
//
// Buffers flits from the GPU and presents the head flit to the router under a
// valid/ready handshake. Also exports full/empty/occupancy, an intra-group
// classification of the head flit, and saturating accept/deliver/drop counters.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   gpu_data/gpu_valid/gpu_dest     flit offered by the GPU
//   gpu_ready                       queue can accept (not full)
//   rtr_data/rtr_valid/rtr_dest     head flit toward the router
//   rtr_ready                       router consumes the head this cycle
//   head_is_local                   head destination is inside GROUP_ID
//   fifo_full/fifo_empty/occupancy  queue status
//   accept_cnt/deliver_cnt/drop_cnt saturating statistics
module leaf_gpu_ingress_queue #(
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] GROUP_ID   = 4'b0100,
    parameter int         CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DWIDTH-1:0]             gpu_data,
    input  logic                          gpu_valid,
    input  logic [5:0]                    gpu_dest,
    output logic                          gpu_ready,
    output logic [DWIDTH-1:0]             rtr_data,
    output logic                          rtr_valid,
    output logic [5:0]                    rtr_dest,
    input  logic                          rtr_ready,
    output logic                          head_is_local,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [CNT_WIDTH-1:0]          accept_cnt,
    output logic [CNT_WIDTH-1:0]          deliver_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam int                   AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          OCC_MAX = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DWIDTH+5:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_occ;
    logic [CNT_WIDTH-1:0] r_accept_cnt;
    logic [CNT_WIDTH-1:0] r_deliver_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Status comes from registered occupancy only, so nothing on the GPU side
    // reaches the router side combinationally and a pop never unblocks a push
    // in the same cycle.
    assign w_full  = (r_occ == OCC_MAX);
    assign w_empty = (r_occ == '0);
    assign w_push  = gpu_valid && !w_full;
    assign w_pop   = rtr_ready && !w_empty;
    assign w_drop  = gpu_valid && w_full;

    assign gpu_ready     = !w_full;
    assign rtr_valid     = !w_empty;
    assign fifo_full     = w_full;
    assign fifo_empty    = w_empty;
    assign occupancy     = r_occ;
    assign accept_cnt    = r_accept_cnt;
    assign deliver_cnt   = r_deliver_cnt;
    assign drop_cnt      = r_drop_cnt;

    // Show-ahead: the head entry is always on the outputs; meaningless when empty.
    assign {rtr_dest, rtr_data} = r_mem[r_rd_ptr];
    assign head_is_local        = !w_empty && (rtr_dest[5:2] == GROUP_ID);

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= {gpu_dest, gpu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_occ         <= '0;
            r_accept_cnt  <= '0;
            r_deliver_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_push && r_accept_cnt != CNT_MAX) begin
                r_accept_cnt <= r_accept_cnt + 1'b1;
            end
            if (w_pop && r_deliver_cnt != CNT_MAX) begin
                r_deliver_cnt <= r_deliver_cnt + 1'b1;
            end
            // A held offer against a full queue counts once per stalled cycle.
            if (w_drop && r_drop_cnt != CNT_MAX) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/leaf_gpu_ingress_queue.md
# leaf_gpu_ingress_queue

Injection buffer between a GPU port and the leaf router's GPU input (`gpu_in_data` / `gpu_in_valid` / `gpu_dest_addr`). It absorbs bursts from the GPU in a show-ahead FIFO and presents one flit per cycle to the router under a valid/ready handshake. It also exports the real full/empty status that the leaf router currently ties off, classifies each head flit as intra-group or inter-group, and counts accepted, delivered and dropped flits.

## Interface
- `DWIDTH`, 16, flit data width.
- `FIFO_DEPTH`, 8, entries; power of two, at least 2.
- `GROUP_ID`, 4'b0100, this leaf's group; compared against `dest[5:2]`.
- `CNT_WIDTH`, 8, width of each statistics counter.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `gpu_data` in DWIDTH: flit from the GPU.
- `gpu_valid` in 1: GPU offers a flit.
- `gpu_dest` in 6: destination address of the offered flit.
- `gpu_ready` out 1: queue can accept; equals `!full`.
- `rtr_data` out DWIDTH: head flit; drives router `gpu_in_data`.
- `rtr_valid` out 1: head is valid; drives router `gpu_in_valid`.
- `rtr_dest` out 6: destination of the head flit; drives router `gpu_dest_addr`.
- `rtr_ready` in 1: router consumes the head this cycle.
- `head_is_local` out 1: `rtr_valid && rtr_dest[5:2]==GROUP_ID`.
- `fifo_full` out 1: queue is full.
- `fifo_empty` out 1: queue is empty.
- `occupancy` out clog2(FIFO_DEPTH)+1: number of entries held.
- `accept_cnt` out CNT_WIDTH: flits pushed.
- `deliver_cnt` out CNT_WIDTH: flits popped.
- `drop_cnt` out CNT_WIDTH: flits offered while full.

## Operation
- Storage is FIFO_DEPTH entries of {dest[5:0], data}. Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo the depth. Occupancy is tracked in a separate counter.
- Push occurs when `gpu_valid && gpu_ready`: the entry is written at the write pointer, the write pointer increments and occupancy increases by 1.
- Pop occurs when `rtr_valid && rtr_ready`: the read pointer increments and occupancy decreases by 1.
- When push and pop happen in the same cycle, both take effect and occupancy is unchanged. This applies at every occupancy level except full (no push) and empty (no pop).
- When full, `gpu_ready`=0 even if a pop occurs that cycle. There is no same-cycle bypass of the full condition.
- When empty, `rtr_valid`=0. There is no combinational path from `gpu_*` to `rtr_*`.
- Output is show-ahead: `rtr_data` and `rtr_dest` always reflect the entry at the read pointer. They are don't-care while `rtr_valid`=0.
- `rtr_valid` = `!fifo_empty`. It is derived from registered occupancy only.
- Flags: `fifo_full` = (occupancy==FIFO_DEPTH); `fifo_empty` = (occupancy==0).
- Counters:
  - `accept_cnt` +1 on each push.
  - `deliver_cnt` +1 on each pop.
  - `drop_cnt` +1 on each cycle with `gpu_valid && !gpu_ready`. The GPU side is expected to hold the flit, so a stalled offer is counted once per stalled cycle.
  - All three saturate at 2^CNT_WIDTH-1; they do not wrap.
- Data is never modified. Flits leave in arrival order.

## Timing
- Reset (synchronous, takes effect at the clock edge while `reset`=1):
  - Pointers, occupancy and all counters go to 0.
  - `fifo_empty`=1, `fifo_full`=0, `rtr_valid`=0, `gpu_ready`=1, `head_is_local`=0.
  - Storage contents are not cleared.
- Reset mid-operation: all queued flits are discarded. A push or pop in the reset cycle is ignored.
- Latency: a flit pushed at edge N is visible with `rtr_valid`=1 after edge N, i.e. in cycle N+1 when the queue was empty. A flit behind k older entries appears after k pops.
- Fill rate: a continuous push stream with `rtr_ready`=0 fills the queue in FIFO_DEPTH cycles. `gpu_ready` falls in the cycle after the FIFO_DEPTH-th push.
- Full state: one pop from full raises `gpu_ready` in the next cycle.
- Throughput: with `gpu_valid`=1 and `rtr_ready`=1 held, the queue sustains 1 flit per cycle at steady state.

## Test plan
- **Reset values:** assert `reset` for 2 cycles → all outputs at the reset values above; `occupancy`=0.
- **Single flit, local:** push data=0x1234, dest=6'b010010 into an empty queue with `rtr_ready`=0 → next cycle `rtr_valid`=1, `rtr_data`=0x1234, `head_is_local`=1, `occupancy`=1. Assert `rtr_ready` for one cycle → `rtr_valid`=0, `deliver_cnt`=1.
- **Fill and drop:** push 10 consecutive flits 0x0001..0x000A with `rtr_ready`=0 → `fifo_full`=1 after 8 pushes, `accept_cnt`=8, `drop_cnt`=2, `gpu_ready`=0. Then drain → flits appear in order 0x0001..0x0008.
- **Simultaneous push/pop:** at occupancy 3, hold push and pop for 20 cycles → occupancy stays 3, order preserved, `accept_cnt` and `deliver_cnt` each +20.
- **Pop at full:** from full, one pop with `gpu_valid`=1 → no push that cycle; next cycle `gpu_ready`=1 and the push is accepted; occupancy returns to 8.
- **Reset mid-stream, remote head:** with 5 entries and head dest=6'b100001 (`head_is_local`=0), pulse `reset` → `rtr_valid`=0, counters 0. A new push after reset is the next flit out.
